// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, opcode values, the command record
// carried through the sequencer FIFO and the sequencer state encoding.
package alu_pkg;

    localparam int OPND_W = 8;
    localparam int OPC_W  = 3;
    localparam int RES_W  = 16;
    localparam int CMD_W  = 2 * OPND_W + OPC_W;

    // Opcodes understood by the ALU; the sequencer passes them through untouched.
    localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
    localparam logic [OPC_W-1:0] OP_AND = 3'b010;
    localparam logic [OPC_W-1:0] OP_OR  = 3'b011;
    localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
    localparam logic [OPC_W-1:0] OP_MUL = 3'b101;
    localparam logic [OPC_W-1:0] OP_SHL = 3'b110;
    localparam logic [OPC_W-1:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_GAP   = 2'b10
    } seq_state_t;

    typedef struct packed {
        logic [OPND_W-1:0] x;
        logic [OPND_W-1:0] y;
        logic [OPC_W-1:0]  op;
    } alu_cmd_t;

    // Bundle the three producer fields into one FIFO word.
    function automatic alu_cmd_t pack_cmd(input logic [OPND_W-1:0] x,
                                          input logic [OPND_W-1:0] y,
                                          input logic [OPC_W-1:0]  op);
        alu_cmd_t c;
        c.x  = x;
        c.y  = y;
        c.op = op;
        return c;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH x WIDTH storage with full/empty flags. A push offered
// while full is dropped even if a pop happens in the same cycle, so the
// producer must watch o_full. The head word is presented combinationally.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; cleared on reset so the head never presents stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: queues {X, Y, op} commands, drives one at a time onto
// the ALU with BEGIN held until END, captures OUT into a one-entry result
// register, and abandons a command if END never arrives within TIMEOUT cycles.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OPND_W-1:0] cmd_x,
    input  logic [OPND_W-1:0] cmd_y,
    input  logic [OPC_W-1:0]  cmd_op,
    output logic [OPND_W-1:0] alu_x,
    output logic [OPND_W-1:0] alu_y,
    output logic [OPC_W-1:0]  alu_op,
    output logic              alu_begin,
    input  logic [RES_W-1:0]  alu_out,
    input  logic              alu_end,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [OPC_W-1:0]  res_op,
    output logic              busy,
    output logic              err_timeout
);

    localparam int              WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    seq_state_t        r_state;
    logic [WD_W-1:0]   r_wd;
    logic [OPND_W-1:0] r_alu_x;
    logic [OPND_W-1:0] r_alu_y;
    logic [OPC_W-1:0]  r_alu_op;
    logic              r_alu_begin;
    logic              r_res_valid;
    logic [RES_W-1:0]  r_res_data;
    logic [OPC_W-1:0]  r_res_op;
    logic              r_err_timeout;

    alu_cmd_t          w_push_cmd;
    alu_cmd_t          w_head;
    logic [CMD_W-1:0]  w_head_bits;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_wd_expired;
    logic              w_can_issue;

    assign w_push_cmd   = pack_cmd(cmd_x, cmd_y, cmd_op);
    assign w_head       = w_head_bits;
    assign w_push       = cmd_valid && !w_full;
    assign w_wd_expired = (r_wd == WD_LAST);
    // The head leaves the FIFO only when its ALU run finishes or is abandoned.
    assign w_pop        = (r_state == ST_ISSUE) && (alu_end || w_wd_expired);
    // Issue only when the result slot will be free before END can come back.
    assign w_can_issue  = !w_empty && (!r_res_valid || res_ready);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign cmd_ready   = !w_full;
    assign alu_x       = r_alu_x;
    assign alu_y       = r_alu_y;
    assign alu_op      = r_alu_op;
    assign alu_begin   = r_alu_begin;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_op      = r_res_op;
    assign err_timeout = r_err_timeout;
    assign busy        = !w_empty || (r_state != ST_IDLE);

    // Sequencer FSM: issue from FIFO head, hold BEGIN until END or watchdog expiry, then one idle gap cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wd          <= {WD_W{1'b0}};
            r_alu_x       <= {OPND_W{1'b0}};
            r_alu_y       <= {OPND_W{1'b0}};
            r_alu_op      <= {OPC_W{1'b0}};
            r_alu_begin   <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_data    <= {RES_W{1'b0}};
            r_res_op      <= {OPC_W{1'b0}};
            r_err_timeout <= 1'b0;
        end else begin
            // Consumer handshake frees the slot; a capture below on the same edge overrides this.
            if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end else begin
                r_res_valid <= r_res_valid;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_can_issue) begin
                        r_alu_x     <= w_head.x;
                        r_alu_y     <= w_head.y;
                        r_alu_op    <= w_head.op;
                        r_alu_begin <= 1'b1;
                        r_wd        <= {WD_W{1'b0}};
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_alu_begin <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (alu_end) begin
                        r_res_data  <= alu_out;
                        r_res_op    <= r_alu_op;
                        r_res_valid <= 1'b1;
                        r_alu_begin <= 1'b0;
                        r_state     <= ST_GAP;
                    end else if (w_wd_expired) begin
                        r_err_timeout <= 1'b1;
                        r_alu_begin   <= 1'b0;
                        r_state       <= ST_GAP;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                ST_GAP: begin
                    // BEGIN stays low for a full cycle so the ALU can return to idle.
                    r_alu_begin <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_alu_begin <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed scenarios followed by a randomized run,
// with a behavioural ALU and a queue of expected results in issue order.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] op;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [2:0]  cmd_op;
    logic [7:0]  alu_x;
    logic [7:0]  alu_y;
    logic [2:0]  alu_op;
    logic        alu_begin;
    logic [15:0] alu_out = 16'h0000;
    logic        alu_end = 1'b0;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_op;
    logic        busy;
    logic        err_timeout;

    int   checks   = 0;
    int   failures = 0;
    cmd_t exp_q[$];

    // ALU model controls
    int m_lat  = 3;
    bit m_hang = 1'b0;
    bit m_junk = 1'b0;
    int m_cnt  = 0;
    int m_cur  = 1;

    alu_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_op      (cmd_op),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_op      (alu_op),
        .alu_begin   (alu_begin),
        .alu_out     (alu_out),
        .alu_end     (alu_end),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_op      (res_op),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // What the ALU computes for a command
    function automatic logic [15:0] alu_fn(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
        case (op)
            OP_ADD:  return {8'd0, x} + {8'd0, y};
            OP_MUL:  return {8'd0, x} * {8'd0, y};
            default: return {x, y} ^ {13'd0, op};
        endcase
    endfunction

    function automatic cmd_t mk(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
        cmd_t c;
        c.x = x;
        c.y = y;
        c.op = op;
        return c;
    endfunction

    // Behavioural ALU: raises END once BEGIN has been high for the latched latency
    always @(negedge clk) begin : alu_model
        int n_cnt;
        int n_lat;
        n_cnt = alu_begin ? m_cnt + 1 : 0;
        n_lat = (alu_begin && m_cnt == 0) ? m_lat : m_cur;
        m_cnt   <= n_cnt;
        m_cur   <= n_lat;
        alu_end <= alu_begin ? (!m_hang && (n_cnt == n_lat)) : m_junk;
        alu_out <= alu_fn(alu_x, alu_y, alu_op);
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
        int w;
        w = 0;
        cmd_valid = 1'b1;
        cmd_x = x;
        cmd_y = y;
        cmd_op = op;
        while (!cmd_ready && w < 200) begin
            tick();
            w++;
        end
        chk("push_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        exp_q.push_back(mk(x, y, op));
    endtask

    task automatic take_result(input string tag, input int hold);
        int   w;
        cmd_t e;
        w = 0;
        while (!res_valid && w < 100) begin
            tick();
            w++;
        end
        chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        repeat (hold) tick();
        chk({tag, "_expected"}, {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, {16'd0, res_data}, {16'd0, alu_fn(e.x, e.y, e.op)});
            chk({tag, "_op"}, {29'd0, res_op}, {29'd0, e.op});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int         hi;
        int         w;
        bit         stable;
        cmd_t       t1;
        logic [7:0] rx;
        logic [7:0] ry;
        logic [2:0] rop;

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_x = 8'd0;
        cmd_y = 8'd0;
        cmd_op = 3'd0;
        res_ready = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_alu_x", {24'd0, alu_x}, 32'd0);
        chk("rst_alu_y", {24'd0, alu_y}, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
        chk("rst_alu_begin", {31'd0, alu_begin}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", {16'd0, res_data}, 32'd0);
        chk("rst_res_op", {29'd0, res_op}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        reset = 1'b0;
        tick();

        // Single command: 2*10 with a 3-cycle ALU
        m_lat = 3;
        push(8'd2, 8'd10, 3'b101);
        chk("single_not_yet", {31'd0, alu_begin}, 32'd0);
        chk("single_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("single_begin", {31'd0, alu_begin}, 32'd1);
        chk("single_x", {24'd0, alu_x}, 32'd2);
        chk("single_y", {24'd0, alu_y}, 32'd10);
        chk("single_op", {29'd0, alu_op}, 32'd5);
        hi = 0;
        while (alu_begin && hi < 20) begin
            hi++;
            tick();
        end
        chk("single_begin_cycles", hi, 32'd3);
        chk("single_res_valid", {31'd0, res_valid}, 32'd1);
        chk("single_res_data", {16'd0, res_data}, 32'h0014);
        chk("single_res_op", {29'd0, res_op}, 32'd5);
        t1 = exp_q.pop_front();
        chk("single_model", {16'd0, res_data}, {16'd0, alu_fn(t1.x, t1.y, t1.op)});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("single_res_cleared", {31'd0, res_valid}, 32'd0);
        chk("single_idle", {31'd0, busy}, 32'd0);

        // FIFO full: a pending result blocks issue while five commands are offered
        m_lat = 2;
        push(8'h11, 8'h22, 3'b001);
        w = 0;
        while (!res_valid && w < 50) begin
            tick();
            w++;
        end
        chk("ff_pending", {31'd0, res_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_x = 8'(8'h30 + i);
            cmd_y = 8'(i);
            cmd_op = 3'b010;
            chk("ff_accept", {31'd0, cmd_ready}, 32'd1);
            tick();
            exp_q.push_back(mk(cmd_x, cmd_y, cmd_op));
        end
        cmd_x = 8'h99;
        cmd_y = 8'h77;
        cmd_op = 3'b110;
        chk("ff_full", {31'd0, cmd_ready}, 32'd0);
        chk("ff_busy", {31'd0, busy}, 32'd1);
        chk("ff_no_issue", {31'd0, alu_begin}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ff_held", {31'd0, cmd_ready}, 32'd0);
        end
        take_result("ff_first", 0);
        w = 0;
        while (!cmd_ready && w < 20) begin
            tick();
            w++;
        end
        chk("ff_pop_latency", w, 32'd2);
        chk("ff_pop_with_result", {31'd0, res_valid}, 32'd1);
        tick();
        chk("ff_fifth_taken", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        exp_q.push_back(mk(8'h99, 8'h77, 3'b110));
        for (int i = 0; i < 5; i++) take_result("ff_drain", 0);

        // Ordering and back-pressure: sums 2,3,4 with the consumer stalled after the first
        m_lat = 3;
        push(8'd1, 8'd1, 3'b000);
        push(8'd2, 8'd1, 3'b000);
        push(8'd3, 8'd1, 3'b000);
        w = 0;
        while (!res_valid && w < 50) begin
            tick();
            w++;
        end
        chk("ord_first_data", {16'd0, res_data}, 32'd2);
        hi = 0;
        repeat (10) begin
            tick();
            if (alu_begin) hi++;
        end
        chk("ord_stalled_issue", hi, 32'd0);
        chk("ord_held_valid", {31'd0, res_valid}, 32'd1);
        take_result("ord_r1", 0);
        chk("ord_issue_after_take", {31'd0, alu_begin}, 32'd1);
        take_result("ord_r2", 1);
        take_result("ord_r3", 2);
        chk("ord_empty", exp_q.size(), 32'd0);

        // END while idle must be ignored
        m_junk = 1'b1;
        repeat (3) tick();
        chk("junk_no_result", {31'd0, res_valid}, 32'd0);
        chk("junk_no_begin", {31'd0, alu_begin}, 32'd0);
        m_junk = 1'b0;
        tick();
        chk("junk_idle", {31'd0, busy}, 32'd0);
        chk("pre_to_err", {31'd0, err_timeout}, 32'd0);

        // Watchdog: hung ALU, second command queued behind it
        m_hang = 1'b1;
        push(8'hA5, 8'h5A, 3'b011);
        cmd_valid = 1'b1;
        cmd_x = 8'h07;
        cmd_y = 8'h09;
        cmd_op = 3'b000;
        tick();
        cmd_valid = 1'b0;
        exp_q.push_back(mk(8'h07, 8'h09, 3'b000));
        hi = 0;
        stable = 1'b1;
        while (alu_begin && hi < 30) begin
            if (alu_x !== 8'hA5 || alu_y !== 8'h5A || alu_op !== 3'b011) stable = 1'b0;
            hi++;
            tick();
        end
        m_hang = 1'b0;
        chk("to_begin_cycles", hi, TIMEOUT);
        chk("to_operands_stable", {31'd0, stable}, 32'd1);
        chk("to_err", {31'd0, err_timeout}, 32'd1);
        chk("to_no_result", {31'd0, res_valid}, 32'd0);
        chk("to_x_held", {24'd0, alu_x}, 32'hA5);
        t1 = exp_q.pop_front();
        take_result("to_next", 0);
        chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);

        // Reset while BEGIN is high with two commands queued
        m_hang = 1'b1;
        push(8'h01, 8'h02, 3'b100);
        push(8'h03, 8'h04, 3'b100);
        push(8'h05, 8'h06, 3'b100);
        chk("rmid_begin_high", {31'd0, alu_begin}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rmid_begin_async", {31'd0, alu_begin}, 32'd0);
        chk("rmid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rmid_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rmid_busy", {31'd0, busy}, 32'd0);
        chk("rmid_err_cleared", {31'd0, err_timeout}, 32'd0);
        exp_q.delete();
        m_hang = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        m_lat = 2;
        push(8'h44, 8'h03, 3'b101);
        chk("rmid_lat_pre", {31'd0, alu_begin}, 32'd0);
        tick();
        chk("rmid_lat_issue", {31'd0, alu_begin}, 32'd1);
        take_result("rmid_res", 0);

        // Randomized traffic: latencies 1..5, random back-pressure
        for (int i = 0; i < 40; i++) begin
            while (exp_q.size() >= DEPTH + 1) take_result("rnd_full", $urandom_range(0, 2));
            m_lat = $urandom_range(1, 5);
            rx = 8'($urandom);
            ry = 8'($urandom);
            rop = 3'($urandom);
            push(rx, ry, rop);
            if ($urandom_range(0, 1) == 1) take_result("rnd", $urandom_range(0, 3));
        end
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            take_result("rnd_drain", $urandom_range(0, 2));
            w++;
        end
        chk("rnd_all_taken", exp_q.size(), 32'd0);
        tick();
        chk("rnd_idle", {31'd0, busy}, 32'd0);
        chk("rnd_no_err", {31'd0, err_timeout}, 32'd0);
        chk("rnd_no_stray", {31'd0, res_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
